// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word-addressed data memory serving the TSC CPU's d_readM/d_writeM port
// Ports: clk, reset_n (async active-low); d_readM/d_writeM request strobes held until d_ready;
// d_address/d_wdata request fields; d_rdata load data (held after d_ready); d_ready one-cycle
// completion pulse; d_error illegal request (valid with d_ready); busy from acceptance through d_ready.
module data_mem_responder #(
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_BITS-1:0] d_address,
  input  logic [WORD_BITS-1:0] d_wdata,
  output logic [WORD_BITS-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_error,
  output logic                 busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_BITS-1:0] addrQ, curAddr;
  logic [WORD_BITS-1:0] wdataQ, curWdata;
  logic writeQ, errQ, req, reqErr, accept, goResp, curWrite, curErr;
  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];
  // With LATENCY==1 the commit edge is the acceptance edge, so the live request fields are used there.
  always_comb begin
    req = d_readM | d_writeM;
    reqErr = (d_readM & d_writeM) | (|d_address[WORD_BITS-1:ADDR_BITS]);
    accept = (state == IDLE) && req;
    goResp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
    curAddr = (state == IDLE) ? d_address[ADDR_BITS-1:0] : addrQ;
    curWdata = (state == IDLE) ? d_wdata : wdataQ;
    curWrite = (state == IDLE) ? d_writeM : writeQ;
    curErr = (state == IDLE) ? reqErr : errQ;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      addrQ <= '0;
      wdataQ <= '0;
      writeQ <= 1'b0;
      errQ <= 1'b0;
      d_rdata <= '0;
      d_ready <= 1'b0;
      d_error <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (accept) begin
        addrQ <= d_address[ADDR_BITS-1:0];
        wdataQ <= d_wdata;
        writeQ <= d_writeM;
        errQ <= reqErr;
      end
      if (goResp && (curErr || !curWrite)) d_rdata <= curErr ? '0 : mem[curAddr];
      d_ready <= goResp;
      d_error <= goResp && curErr;
      busy <= goResp || accept || (state == WAIT);
      cnt <= accept ? 4'(LATENCY - 1) : (state == WAIT) ? cnt - 4'd1 : cnt;
      state <= goResp ? RESP : accept ? WAIT : (state == WAIT) ? WAIT : IDLE;
    end
  // Array has no reset; gating with reset_n drops a commit that coincides with reset.
  always_ff @(posedge clk)
    if (reset_n && goResp && curWrite && !curErr) mem[curAddr] <= curWdata;
endmodule
